mio_access_ctrl: RTL and testbench
==================================

// Module: mio_access_ctrl
// PURPOSE
//  Memory-side access sequencer between the multi-cycle CPU control FSM and the MIO bus.
//  Consumes MemRead/MemWrite plus the IorD-selected address and write data.
//  Runs a req/ack bus transaction with timeout and captures read data into rdata (MDR).
//  Returns MIO_ready to the control FSM, which holds in IF until MIO_ready is seen.
// PARAMETERS
//  ADDR_W   32  address width (byte address)
//  DATA_W   32  data width
//  TIMEOUT  16  max cycles in REQ without bus_ack before abort (>=2)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  MemRead    in   1       read request from control FSM (level)
//  MemWrite   in   1       write request from control FSM (level)
//  addr       in   ADDR_W  access address (PC or ALUOut per IorD)
//  wdata      in   DATA_W  store data (register B)
//  rdata      out  DATA_W  memory data register, valid from MIO_ready pulse onward
//  MIO_ready  out  1       one-cycle pulse: access complete (or aborted)
//  mem_err    out  1       one-cycle pulse coincident with MIO_ready on abort/fault
//  busy       out  1       high in any state other than IDLE
//  bus_req    out  1       bus request, held until ack or timeout
//  bus_we     out  1       1 = write, 0 = read; stable while bus_req
//  bus_addr   out  ADDR_W  latched address; stable while bus_req
//  bus_wdata  out  DATA_W  latched store data; stable while bus_req
//  bus_rdata  in   DATA_W  read data, sampled in the cycle bus_ack=1
//  bus_ack    in   1       slave completion, sampled only while bus_req=1
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; rdata, MIO_ready, mem_err, busy, bus_req, bus_we,
//   bus_addr, bus_wdata, timeout counter all 0. Applies immediately, also mid-transaction.
//  FSM states: IDLE, REQ, DONE. All outputs registered.
//  IDLE: sample MemRead/MemWrite each cycle.
//   - exactly one asserted, addr[1:0]==0: latch addr/wdata/we, clear counter -> REQ.
//   - exactly one asserted, addr[1:0]!=0 (misaligned): no bus cycle; set err flag -> DONE.
//   - both asserted: illegal; no bus cycle; set err flag -> DONE.
//   - neither asserted: stay IDLE.
//  REQ: bus_req=1; bus_we/bus_addr/bus_wdata held constant.
//   - bus_ack=1: on read, rdata<=bus_rdata; on write, rdata unchanged -> DONE, err flag=0.
//   - else counter++; when counter==TIMEOUT-1 with no ack: err flag=1 -> DONE
//     (bus_req drops; rdata unchanged).
//  DONE: MIO_ready=1 and mem_err=err flag for exactly one cycle; bus_req=0 -> IDLE.
//  Latency: request seen in IDLE at cycle 0; bus_req high from cycle 1; ack at cycle k
//   gives MIO_ready at cycle k+1 (min 2 cycles for zero-wait slave).
//  A request still held after DONE is re-accepted in IDLE as a new access.
//   The requester drops MemRead/MemWrite on MIO_ready; no implicit merging.
//  Requests arriving while busy=1 are ignored (not queued).
//  bus_ack while bus_req=0 is ignored. Counter saturates; it never wraps.
//  rdata holds its value until the next successful read or reset.
// TESTING
//  1. Reset mid-REQ: assert reset_n=0 while bus_req=1 -> bus_req, busy, rdata go 0
//     immediately; FSM is IDLE on release.
//  2. Read, zero-wait: MemRead=1, addr=0x0000_0004, ack in first REQ cycle with
//     bus_rdata=0x2010_0005 -> MIO_ready at cycle 2, rdata=0x2010_0005, mem_err=0.
//  3. Write, 3 wait states: MemWrite=1, addr=0x10, wdata=0xDEAD_BEEF -> bus_we=1 and
//     fields stable 4 cycles; MIO_ready one cycle after ack; rdata unchanged.
//  4. Timeout: MemRead=1, bus_ack never -> bus_req high exactly TIMEOUT-1 cycles, then
//     MIO_ready=1 with mem_err=1; rdata unchanged.
//  5. Faults: addr=0x6 with MemRead=1 -> no bus_req, MIO_ready+mem_err at cycle 1.
//     MemRead=MemWrite=1 -> same response.
//  6. Held request: keep MemRead=1 through DONE -> second transaction starts;
//     MIO_ready pulses never exceed one cycle.

Source files
------------

// File: rtl/mio_access_ctrl_if.sv
// rtl/mio_access_ctrl_if.sv - control-FSM request side and MIO bus side of the access sequencer
interface mio_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              MIO_ready;
  logic              mem_err;
  logic              busy;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  // slave: the sequencer's view; master: CPU control FSM plus bus slave
  modport slave (
    input  MemRead, MemWrite, addr, wdata, bus_rdata, bus_ack,
    output rdata, MIO_ready, mem_err, busy, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output MemRead, MemWrite, addr, wdata, bus_rdata, bus_ack,
    input  rdata, MIO_ready, mem_err, busy, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mio_access_ctrl.sv
// rtl/mio_access_ctrl.sv - MIO bus access sequencer with req/ack handshake, timeout and MDR capture
module mio_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  mio_access_ctrl_if.slave mio
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_bus_req;
  logic              r_mio_ready;
  logic              r_mem_err;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_rdata;

  state_t            w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_err_next;
  logic              w_latch;
  logic              w_capture;
  logic              w_one_req;
  logic              w_both_req;
  logic              w_aligned;

  assign w_one_req  = mio.MemRead ^ mio.MemWrite;
  assign w_both_req = mio.MemRead & mio.MemWrite;
  assign w_aligned  = (mio.addr[1:0] == 2'b00);
  assign w_cnt_inc  = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err_next   = 1'b0;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_one_req && w_aligned) begin
          w_latch      = 1'b1;
          w_state_next = ST_REQ;
        end else if (w_one_req || w_both_req) begin
          // misaligned or conflicting request: answer with an error, never touch the bus
          w_err_next   = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_REQ: begin
        if (mio.bus_ack) begin
          w_capture    = ~r_bus_we;
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_LAST) begin
            w_err_next   = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // outputs are registered from the next state so they line up with r_state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_mio_ready <= 1'b0;
      r_mem_err   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_bus_req   <= (w_state_next == ST_REQ);
      r_mio_ready <= (w_state_next == ST_DONE);
      r_mem_err   <= (w_state_next == ST_DONE) & w_err_next;
      if (w_latch) begin
        r_bus_we    <= mio.MemWrite;
        r_bus_addr  <= mio.addr;
        r_bus_wdata <= mio.wdata;
      end
      if (w_capture) begin
        r_rdata <= mio.bus_rdata;
      end
    end
  end

  assign mio.rdata     = r_rdata;
  assign mio.MIO_ready = r_mio_ready;
  assign mio.mem_err   = r_mem_err;
  assign mio.busy      = r_busy;
  assign mio.bus_req   = r_bus_req;
  assign mio.bus_we    = r_bus_we;
  assign mio.bus_addr  = r_bus_addr;
  assign mio.bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_mio_access_ctrl.sv
// tb/tb_mio_access_ctrl.sv - directed scoreboard bench for mio_access_ctrl
module tb_mio_access_ctrl;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata;

  mio_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mio ();

  mio_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mio     (mio)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s/sb: observed=MIO_ready expected=no pending entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "/rdata"}, 64'(mio.rdata), 64'(e.rdata));
      check({tag, "/mem_err"}, 64'(mio.mem_err), 64'(e.err));
    end
  endtask

  // waits < 0 means the slave never acknowledges
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd, input int waits,
                            input logic [31:0] slave_data, input int exp_req, input int exp_rdy);
    exp_t e;
    logic fault;
    int   cyc;
    int   req_cyc;
    int   rdy_cyc;
    logic done;
    fault = (rd && wr) || (a[1:0] != 2'b00);
    e.err = fault || (waits < 0);
    if (!e.err && rd) model_rdata = slave_data;
    e.rdata = model_rdata;
    sb.push_back(e);
    mio.MemRead = rd;
    mio.MemWrite = wr;
    mio.addr = a;
    mio.wdata = wd;
    cyc = 0;
    req_cyc = 0;
    rdy_cyc = -1;
    done = 1'b0;
    while (!done && cyc < 64) begin
      tick();
      cyc++;
      mio.bus_ack = 1'b0;
      mio.bus_rdata = $urandom;
      if (mio.MIO_ready) begin
        rdy_cyc = cyc;
        done = 1'b1;
        mio.MemRead = 1'b0;
        mio.MemWrite = 1'b0;
        sb_pop(tag);
      end else if (mio.bus_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          check({tag, "/bus_we"}, 64'(mio.bus_we), 64'(wr));
          check({tag, "/bus_addr"}, 64'(mio.bus_addr), 64'(a));
          check({tag, "/bus_wdata"}, 64'(mio.bus_wdata), 64'(wd));
        end else if (mio.bus_we !== wr || mio.bus_addr !== a || mio.bus_wdata !== wd) begin
          check({tag, "/stable"}, {mio.bus_we, mio.bus_addr}, {wr, a});
        end
        if (waits >= 0 && req_cyc == waits + 1) begin
          mio.bus_ack = 1'b1;
          mio.bus_rdata = slave_data;
        end
      end
    end
    check({tag, "/ready_cycle"}, 64'(rdy_cyc), 64'(exp_rdy));
    check({tag, "/req_cycles"}, 64'(req_cyc), 64'(exp_req));
    tick();
    check({tag, "/ready_pulse"}, 64'(mio.MIO_ready), 64'(0));
  endtask

  initial begin
    int   pulses;
    int   nreq;
    int   r1;
    int   r2;
    logic prev_rdy;
    exp_t e;

    reset_n = 1'b0;
    mio.MemRead = 1'b0;
    mio.MemWrite = 1'b0;
    mio.addr = '0;
    mio.wdata = '0;
    mio.bus_rdata = '0;
    mio.bus_ack = 1'b0;
    model_rdata = '0;
    tick();
    tick();
    check("rst/bus_req", 64'(mio.bus_req), 64'(0));
    check("rst/busy", 64'(mio.busy), 64'(0));
    check("rst/ready", 64'(mio.MIO_ready), 64'(0));
    check("rst/mem_err", 64'(mio.mem_err), 64'(0));
    check("rst/rdata", 64'(mio.rdata), 64'(0));
    check("rst/bus_fields", {mio.bus_we, mio.bus_addr, mio.bus_wdata}, 64'(0));
    reset_n = 1'b1;
    tick();
    check("idle/busy", 64'(mio.busy), 64'(0));

    run_access("rd0", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 0, 32'h2010_0005, 1, 2);
    run_access("wr3", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h5555_AAAA, 4, 5);

    mio.bus_ack = 1'b1;
    mio.bus_rdata = 32'hBAD0_0BAD;
    tick();
    tick();
    mio.bus_ack = 1'b0;
    check("stray_ack/rdata", 64'(mio.rdata), 64'(model_rdata));
    check("stray_ack/busy", 64'(mio.busy), 64'(0));

    run_access("tmo", 1'b1, 1'b0, 32'h0000_0020, 32'h0, -1, 32'h0, TIMEOUT - 1, TIMEOUT);
    run_access("misalign", 1'b1, 1'b0, 32'h0000_0006, 32'h0, 0, 32'h0, 0, 1);
    run_access("both", 1'b1, 1'b1, 32'h0000_0008, 32'h0, 0, 32'h0, 0, 1);

    e.err = 1'b0;
    e.rdata = 32'hA5A5_0001;
    sb.push_back(e);
    e.rdata = 32'hA5A5_0002;
    sb.push_back(e);
    model_rdata = 32'hA5A5_0002;
    mio.MemRead = 1'b1;
    mio.addr = 32'h0000_0020;
    pulses = 0;
    nreq = 0;
    r1 = -1;
    r2 = -1;
    prev_rdy = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      mio.bus_ack = 1'b0;
      mio.bus_rdata = $urandom;
      if (mio.MIO_ready) begin
        check("held/pulse_width", 64'(prev_rdy), 64'(0));
        pulses++;
        if (pulses == 1) r1 = cyc;
        if (pulses == 2) begin
          r2 = cyc;
          mio.MemRead = 1'b0;
        end
        sb_pop("held");
      end else if (mio.bus_req) begin
        mio.bus_ack = 1'b1;
        mio.bus_rdata = (nreq == 0) ? 32'hA5A5_0001 : 32'hA5A5_0002;
        nreq++;
      end
      prev_rdy = mio.MIO_ready;
    end
    check("held/pulses", 64'(pulses), 64'(2));
    check("held/first", 64'(r1), 64'(2));
    check("held/second", 64'(r2), 64'(5));

    mio.MemRead = 1'b1;
    mio.addr = 32'h0000_0008;
    tick();
    check("midrst/bus_req_before", 64'(mio.bus_req), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst/bus_req", 64'(mio.bus_req), 64'(0));
    check("midrst/busy", 64'(mio.busy), 64'(0));
    check("midrst/rdata", 64'(mio.rdata), 64'(0));
    mio.MemRead = 1'b0;
    model_rdata = '0;
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst/idle_busy", 64'(mio.busy), 64'(0));
    check("midrst/idle_req", 64'(mio.bus_req), 64'(0));
    run_access("rd_post", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678, 2, 3);

    check("sb/empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
